// File: rtl/serial_adder.sv
// Bit-serial adder: operands are loaded on an accepted start, then one bit
// per clock is added LSB first through a single full-adder cell and a carry
// flip-flop. The result is presented with a one-cycle done strobe.

// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cy_q, cy_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fa_s;
  logic               fa_co;

  // The one adder cell always looks at the current LSBs and the carry.
  fa u_fa (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (cy_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Next-state and datapath update: load on accepted start, shift during RUN.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cy_d    = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        cy_d  = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status strobes decode the state register only.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
